// File: rtl/lfsr_seq_ctrl.sv
// Command sequencer for the 212-bit scrambler LFSR: optional seed load as 32-bit word writes, then a run of enable cycles.
// Optional abort input is honoured only when LFSR_SEQ_CTRL_ABORT_EN is defined.
module lfsr_seq_ctrl #(
    parameter int          POLY_WIDTH = 212,
    parameter logic [11:0] BASE_ADDR  = 12'h0de,
    parameter int          LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_load,
    input  logic [POLY_WIDTH-1:0] cmd_seed,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  abort,
    output logic                  lfsr_write,
    output logic [11:0]           lfsr_addr,
    output logic [31:0]           lfsr_din,
    output logic                  lfsr_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  done_aborted,
    output logic [LEN_WIDTH-1:0]  steps_done
);

    localparam int NW = (POLY_WIDTH + 31) / 32;
    localparam int KW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(NW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state;
    logic [POLY_WIDTH-1:0]   seed_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [KW-1:0]           word_k;
    logic [LEN_WIDTH-1:0]    step_next;
    logic                    abort_hit;

`ifdef LFSR_SEQ_CTRL_ABORT_EN
    assign abort_hit = abort;
`else
    logic unused_abort;
    assign unused_abort = abort;
    assign abort_hit    = 1'b0;
`endif

    assign step_next = steps_done + LEN_WIDTH'(1);

    // Top word is zero-padded above POLY_WIDTH.
    function automatic logic [31:0] seed_word(input logic [POLY_WIDTH-1:0] s,
                                              input logic [KW-1:0] k);
        logic [NW*32-1:0] p;
        p = '0;
        p[POLY_WIDTH-1:0] = s;
        return p[32*k +: 32];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cmd_ready    <= 1'b1;
            lfsr_write   <= 1'b0;
            lfsr_enable  <= 1'b0;
            lfsr_addr    <= '0;
            lfsr_din     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            done_aborted <= 1'b0;
            steps_done   <= '0;
            seed_q       <= '0;
            len_q        <= '0;
            word_k       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        seed_q     <= cmd_seed;
                        len_q      <= cmd_len;
                        steps_done <= '0;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        word_k     <= '0;
                        if (cmd_load) begin
                            state      <= LOAD;
                            lfsr_write <= 1'b1;
                            lfsr_addr  <= BASE_ADDR;
                            lfsr_din   <= seed_word(cmd_seed, '0);
                        end else if (cmd_len != '0) begin
                            state       <= RUN;
                            lfsr_enable <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    // The word on the bus this cycle is always written; abort only stops the next one.
                    if (abort_hit || word_k == LAST_K) begin
                        lfsr_write <= 1'b0;
                        if (abort_hit) begin
                            state        <= DONE;
                            done         <= 1'b1;
                            done_aborted <= 1'b1;
                        end else if (len_q != '0) begin
                            state       <= RUN;
                            lfsr_enable <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        word_k    <= word_k + KW'(1);
                        lfsr_addr <= BASE_ADDR + 12'(word_k) + 12'd1;
                        lfsr_din  <= seed_word(seed_q, word_k + KW'(1));
                    end
                end
                RUN: begin
                    steps_done <= step_next;
                    if (abort_hit || step_next == len_q) begin
                        state        <= DONE;
                        lfsr_enable  <= 1'b0;
                        done         <= 1'b1;
                        done_aborted <= abort_hit;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    done         <= 1'b0;
                    done_aborted <= 1'b0;
                    busy         <= 1'b0;
                    cmd_ready    <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl; abort expectations follow LFSR_SEQ_CTRL_ABORT_EN.
module tb_lfsr_seq_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_load;
    logic [211:0] cmd_seed;
    logic [15:0]  cmd_len;
    logic         abort;
    logic         lfsr_write;
    logic [11:0]  lfsr_addr;
    logic [31:0]  lfsr_din;
    logic         lfsr_enable;
    logic         busy;
    logic         done;
    logic         done_aborted;
    logic [15:0]  steps_done;

    int tests  = 0;
    int errors = 0;

    localparam logic [211:0] SEED =
        212'h65A5A_A5055A5A_A5045A5A_A5035A5A_A5025A5A_A5015A5A_A5005A5A;
    logic [31:0] exp_words [7] = '{32'hA5005A5A, 32'hA5015A5A, 32'hA5025A5A,
                                   32'hA5035A5A, 32'hA5045A5A, 32'hA5055A5A,
                                   32'h00065A5A};

    lfsr_seq_ctrl dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_load(cmd_load), .cmd_seed(cmd_seed), .cmd_len(cmd_len), .abort(abort),
        .lfsr_write(lfsr_write), .lfsr_addr(lfsr_addr), .lfsr_din(lfsr_din),
        .lfsr_enable(lfsr_enable), .busy(busy), .done(done),
        .done_aborted(done_aborted), .steps_done(steps_done)
    );

    always #5 clk = ~clk;

    // Status vector: {cmd_ready, busy, lfsr_write, lfsr_enable, done, done_aborted}
    wire [5:0] obs = {cmd_ready, busy, lfsr_write, lfsr_enable, done, done_aborted};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents a command, lets the accept edge pass, leaves the bench in cycle 1.
    task automatic issue(input logic load, input logic [211:0] seed, input logic [15:0] len);
        cmd_valid = 1'b1;
        cmd_load  = load;
        cmd_seed  = seed;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests++;
        if (obs !== 6'b100000) begin
            errors++;
            $display("FAIL reset_status: got %b expected %b", obs, 6'b100000);
        end
        tests++;
        if (lfsr_addr !== 12'h000 || lfsr_din !== 32'h0 || steps_done !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: addr=%h din=%h steps=%0d expected 0/0/0",
                     lfsr_addr, lfsr_din, steps_done);
        end
    endtask

    task automatic test_load_run;
        logic [5:0] exp;
        issue(1'b1, SEED, 16'd3);
        for (int c = 1; c <= 11; c++) begin
            exp = {1'b0, 1'b1, (c <= 7), (c >= 8 && c <= 10), (c == 11), 1'b0};
            tests++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL load_run_status c=%0d: got %b expected %b", c, obs, exp);
            end
            if (c <= 7) begin
                tests++;
                if (lfsr_addr !== 12'(12'h0de + c - 1) || lfsr_din !== exp_words[c-1]) begin
                    errors++;
                    $display("FAIL load_run_word c=%0d: addr=%h din=%h expected %h/%h", c,
                             lfsr_addr, lfsr_din, 12'(12'h0de + c - 1), exp_words[c-1]);
                end
            end
            if (c == 8) begin
                tests++;
                if (lfsr_addr !== 12'h0e4 || lfsr_din !== 32'h00065A5A) begin
                    errors++;
                    $display("FAIL load_run_hold: addr=%h din=%h expected 0e4/00065a5a",
                             lfsr_addr, lfsr_din);
                end
            end
            if (c == 11) begin
                tests++;
                if (steps_done !== 16'd3) begin
                    errors++;
                    $display("FAIL load_run_steps: got %0d expected 3", steps_done);
                end
            end
            tick();
        end
        tests++;
        if (obs !== 6'b100000 || steps_done !== 16'd3) begin
            errors++;
            $display("FAIL load_run_idle: status=%b steps=%0d expected 100000/3", obs, steps_done);
        end
    endtask

    task automatic test_run_only;
        issue(1'b0, '0, 16'd1);
        tests++;
        if (obs !== 6'b010100) begin
            errors++;
            $display("FAIL run1_c1: got %b expected %b", obs, 6'b010100);
        end
        tick();
        tests++;
        if (obs !== 6'b010010 || steps_done !== 16'd1) begin
            errors++;
            $display("FAIL run1_done: status=%b steps=%0d expected 010010/1", obs, steps_done);
        end
        tick();
        tests++;
        if (obs !== 6'b100000) begin
            errors++;
            $display("FAIL run1_idle: got %b expected %b", obs, 6'b100000);
        end
    endtask

    task automatic test_zero_len;
        logic [5:0] exp;
        issue(1'b0, '0, 16'd0);
        tests++;
        if (obs !== 6'b010010 || steps_done !== 16'd0) begin
            errors++;
            $display("FAIL zero_noload_done: status=%b steps=%0d expected 010010/0", obs, steps_done);
        end
        tick();
        tests++;
        if (obs !== 6'b100000) begin
            errors++;
            $display("FAIL zero_noload_idle: got %b expected %b", obs, 6'b100000);
        end
        issue(1'b1, SEED, 16'd0);
        for (int c = 1; c <= 8; c++) begin
            exp = {1'b0, 1'b1, (c <= 7), 1'b0, (c == 8), 1'b0};
            tests++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL zero_load_status c=%0d: got %b expected %b", c, obs, exp);
            end
            tick();
        end
        tests++;
        if (obs !== 6'b100000 || steps_done !== 16'd0) begin
            errors++;
            $display("FAIL zero_load_idle: status=%b steps=%0d expected 100000/0", obs, steps_done);
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] exp;
        cmd_valid = 1'b1;
        cmd_load  = 1'b0;
        cmd_len   = 16'd2;
        tick();
        cmd_len = 16'd5;
        for (int c = 1; c <= 10; c++) begin
            if (c == 5) begin
                cmd_len   = 16'd9;
                cmd_valid = 1'b0;
            end
            exp = {(c == 4), (c != 4), 1'b0, (c == 1 || c == 2 || (c >= 5 && c <= 9)),
                   (c == 3 || c == 10), 1'b0};
            tests++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL b2b_status c=%0d: got %b expected %b", c, obs, exp);
            end
            if (c == 3 || c == 10) begin
                tests++;
                if (steps_done !== ((c == 3) ? 16'd2 : 16'd5)) begin
                    errors++;
                    $display("FAIL b2b_steps c=%0d: got %0d expected %0d", c, steps_done,
                             (c == 3) ? 2 : 5);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid;
        issue(1'b0, '0, 16'd20);
        for (int c = 1; c < 5; c++) tick();
        tests++;
        if (lfsr_enable !== 1'b1 || steps_done !== 16'd4) begin
            errors++;
            $display("FAIL rstmid_pre: en=%b steps=%0d expected 1/4", lfsr_enable, steps_done);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (obs !== 6'b100000 || lfsr_addr !== 12'h0 || lfsr_din !== 32'h0 || steps_done !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_reset: status=%b addr=%h din=%h steps=%0d expected 100000/0/0/0",
                     obs, lfsr_addr, lfsr_din, steps_done);
        end
        issue(1'b0, '0, 16'd2);
        tick();
        tick();
        tests++;
        if (obs !== 6'b010010 || steps_done !== 16'd2) begin
            errors++;
            $display("FAIL rstmid_next: status=%b steps=%0d expected 010010/2", obs, steps_done);
        end
        tick();
    endtask

    task automatic test_abort;
        issue(1'b0, '0, 16'd10);
        for (int c = 1; c < 4; c++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
`ifdef LFSR_SEQ_CTRL_ABORT_EN
        tests++;
        if (obs !== 6'b010011 || steps_done !== 16'd4) begin
            errors++;
            $display("FAIL abort_done: status=%b steps=%0d expected 010011/4", obs, steps_done);
        end
        tick();
`else
        tests++;
        if (obs !== 6'b010100) begin
            errors++;
            $display("FAIL abort_ignored: got %b expected %b", obs, 6'b010100);
        end
        for (int c = 5; c < 11; c++) tick();
        tests++;
        if (obs !== 6'b010010 || steps_done !== 16'd10) begin
            errors++;
            $display("FAIL abort_full_run: status=%b steps=%0d expected 010010/10", obs, steps_done);
        end
        tick();
`endif
        tests++;
        if (obs !== 6'b100000) begin
            errors++;
            $display("FAIL abort_idle: got %b expected %b", obs, 6'b100000);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        cmd_seed  = '0;
        cmd_len   = '0;
        abort     = 1'b0;
        test_reset();
        test_load_run();
        test_run_only();
        test_zero_len();
        test_back_to_back();
        test_reset_mid();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_seq_ctrl.md
Name: lfsr_seq_ctrl

Overview:
- Command-driven sequencer for the 212-bit primary scrambler LFSR.
- Accepts one command at a time from an upstream requester via valid/ready.
- Optionally loads a full seed as seven 32-bit register writes, then asserts the LFSR enable for a programmed number of cycles. Each enabled cycle advances the LFSR by NUM_OF_STEPS.
- Sits between the scrambler's config/control master and the LFSR's write/addr/lfsrdin/enable inputs, and is their only driver.

Parameters:
- POLY_WIDTH, 212: LFSR width; number of words NW = ceil(POLY_WIDTH/32) = 7.
- BASE_ADDR, 12'h0de: address of seed word 0; word k goes to BASE_ADDR+k.
- LEN_WIDTH, 16: width of the run-length field and step counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller idle and able to accept.
- cmd_load  in  1  1 = write cmd_seed before running.
- cmd_seed  in  POLY_WIDTH  seed value; sampled at accept.
- cmd_len  in  LEN_WIDTH  number of enable cycles; sampled at accept.
- abort  in  1  terminate current command (only with macro).
- lfsr_write  out  1  to LFSR write.
- lfsr_addr  out  12  to LFSR addr.
- lfsr_din  out  32  to LFSR lfsrdin.
- lfsr_enable  out  1  to LFSR enable.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- done_aborted  out  1  qualifies done; 1 = command terminated by abort.
- steps_done  out  LEN_WIDTH  enable cycles issued by last command; held until next accept.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Registered outputs: all outputs are registered.
- Reset values: cmd_ready=1; lfsr_write, lfsr_enable, busy, done and done_aborted = 0; lfsr_addr=0; lfsr_din=0; steps_done=0; state IDLE.
- Reset mid-command: outputs return to reset values at the next edge. A partially written seed is left in the LFSR.
- Accept: accept = cmd_valid & cmd_ready, in IDLE only. On accept:
  - seed, len and load are captured;
  - steps_done is cleared;
  - cmd_ready=0 and busy=1 from the next cycle.
- States: IDLE, LOAD, RUN, DONE.
- IDLE -> LOAD on accept with cmd_load=1.
- IDLE -> RUN on accept with cmd_load=0 and len>0.
- IDLE -> DONE on accept with cmd_load=0 and len=0.
- LOAD, word index k = 0..6, one word per cycle:
  - lfsr_write=1, lfsr_addr=BASE_ADDR+k, lfsr_din=seed[32k+31:32k];
  - word 6 carries seed[211:192] zero-extended in bits 31:20.
  - After k=6: -> RUN if len>0, else -> DONE.
- RUN: lfsr_enable=1 for exactly len consecutive cycles.
  - lfsr_write=0 throughout; write and enable are never both 1.
  - steps_done increments once per enable cycle.
  - Then -> DONE.
- DONE: one cycle with done=1, busy=1, all LFSR-side strobes 0. Then -> IDLE, where cmd_ready=1.
- Latency (accept edge closes cycle 0):
  - load with len L: writes in cycles 1–7, enable in cycles 8..7+L, done in cycle 8+L;
  - no load: enable in cycles 1..L, done in cycle L+1;
  - load with L=0: done in cycle 8;
  - no load with L=0: done in cycle 1.
- Back-to-back commands: the earliest next accept is the cycle after done. There is always at least one enable-low cycle between runs, which satisfies the LFSR's delayed-enable shift gating.
- Idle outputs: lfsr_addr and lfsr_din hold their last value when lfsr_write=0. The downstream block decodes only while write is high.
- cmd_valid while busy: ignored; cmd_seed and cmd_len may change freely.

Optional Feature:
- Macro: LFSR_SEQ_CTRL_ABORT_EN.
- With the macro defined, abort=1 in LOAD or RUN:
  - forces the next state to DONE; the current cycle's strobe still completes;
  - done=1 and done_aborted=1 in DONE;
  - steps_done reports enable cycles actually issued;
  - words already written remain in the LFSR.
- With the macro defined, abort in IDLE or DONE is ignored.
- Without the macro: abort is present but ignored, done_aborted is tied to 0, and sequencing always runs to completion.

Test Plan:
- Reset, then cmd_load=1, cmd_seed=212'h…A5 pattern, cmd_len=3 -> seven writes at addrs 0x0de–0x0e4 with the correct 32-bit slices (word 6 upper 12 bits 0), then enable high for cycles 8–10, done in cycle 11, steps_done=3.
- cmd_load=0, cmd_len=1 -> enable high only in cycle 1, done in cycle 2, steps_done=1, write never asserted.
- cmd_load=0, cmd_len=0 -> no strobes, done in cycle 1, cmd_ready back high in cycle 2. Also cmd_load=1, cmd_len=0 -> 7 writes, done in cycle 8.
- Two commands with cmd_valid held high -> second accept the cycle after the first done, enable low in at least one cycle between runs, second command's cmd_seed/cmd_len changed while busy are not sampled.
- rst asserted in RUN cycle 5 of len=20 -> all outputs at reset values the next cycle, cmd_ready=1, and a new command is accepted normally.
- With LFSR_SEQ_CTRL_ABORT_EN: abort during the 4th enable cycle of len=10 -> done with done_aborted=1 the next cycle, steps_done=4. Without the macro, the same stimulus gives done_aborted=0 and steps_done=10.
